// File: rtl/instr_fetch.sv
// Instruction fetch stage: pc register, imem handshake, IF/ID pipeline register.
// A skid register catches a returned word while decode stalls; DISCARD drains a stale request.
module instr_fetch (
  input  logic        clk,
  input  logic        rst,
  input  logic        pc_en,
  input  logic        pc_src,
  input  logic [31:0] branch_target,
  input  logic        jump,
  input  logic [25:0] jump_index,
  input  logic        flush,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] if_id_inst,
  output logic [31:0] if_id_pc4,
  output logic        if_id_valid,
  output logic [5:0]  opcode
);

  typedef enum logic [1:0] {IDLE, FETCH, HOLD, DISCARD} state_t;

  state_t      state, state_n;
  logic [31:0] pc, pc_n;
  logic [31:0] skid, skid_n;
  logic [31:0] oaddr, oaddr_n;
  logic [31:0] inst_n, pc4_n;
  logic        valid_n;

  logic        redirect;
  logic [31:0] target;
  logic [31:0] pc_plus4;
  logic        load;
  logic [31:0] load_word;

  assign redirect = jump | pc_src;
  assign target   = jump ? {if_id_pc4[31:28], jump_index, 2'b00} : branch_target;
  assign pc_plus4 = pc + 32'd4;

  // DISCARD keeps presenting the abandoned address until memory answers it
  assign imem_req  = (state == FETCH) || (state == DISCARD);
  assign imem_addr = (state == DISCARD) ? oaddr : pc;
  assign opcode    = if_id_inst[31:26];

  always_comb begin
    state_n   = state;
    pc_n      = pc;
    skid_n    = skid;
    oaddr_n   = oaddr;
    inst_n    = if_id_inst;
    pc4_n     = if_id_pc4;
    valid_n   = if_id_valid;
    load      = 1'b0;
    load_word = imem_rdata;

    case (state)
      IDLE: state_n = FETCH;
      FETCH: begin
        if (redirect) begin
          pc_n = target;
          if (!imem_ready) begin
            oaddr_n = pc;
            state_n = DISCARD;
          end
        end else if (imem_ready) begin
          if (pc_en) begin
            load      = 1'b1;
            load_word = imem_rdata;
            pc_n      = pc_plus4;
          end else begin
            skid_n  = imem_rdata;
            state_n = HOLD;
          end
        end
      end
      HOLD: begin
        if (redirect) begin
          pc_n    = target;
          state_n = FETCH;
        end else if (pc_en) begin
          load      = 1'b1;
          load_word = skid;
          pc_n      = pc_plus4;
          state_n   = FETCH;
        end
      end
      DISCARD: begin
        if (redirect) pc_n = target;
        if (imem_ready) state_n = FETCH;
      end
      default: state_n = IDLE;
    endcase

    if (load && !flush) begin
      inst_n  = load_word;
      pc4_n   = pc_plus4;
      valid_n = 1'b1;
    end

    // Redirects in IDLE are ignored entirely, so they do not squash IF/ID either
    if (flush || (redirect && state != IDLE)) begin
      inst_n  = 32'h0;
      valid_n = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      pc          <= 32'h0;
      skid        <= 32'h0;
      oaddr       <= 32'h0;
      if_id_inst  <= 32'h0;
      if_id_pc4   <= 32'h0;
      if_id_valid <= 1'b0;
    end else begin
      state       <= state_n;
      pc          <= pc_n;
      skid        <= skid_n;
      oaddr       <= oaddr_n;
      if_id_inst  <= inst_n;
      if_id_pc4   <= pc4_n;
      if_id_valid <= valid_n;
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Directed testbench for instr_fetch: fixed vectors with hand-computed expectations,
// one task per scenario, outputs sampled 1ns after the rising edge.
module tb_instr_fetch;

  logic        clk = 1'b0;
  logic        rst, pc_en, pc_src, jump, flush, imem_ready;
  logic [31:0] branch_target, imem_rdata;
  logic [25:0] jump_index;
  logic        imem_req, if_id_valid;
  logic [31:0] imem_addr, if_id_inst, if_id_pc4;
  logic [5:0]  opcode;

  int checks = 0;
  int errors = 0;

  instr_fetch dut (
    .clk(clk), .rst(rst), .pc_en(pc_en), .pc_src(pc_src),
    .branch_target(branch_target), .jump(jump), .jump_index(jump_index),
    .flush(flush), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ready(imem_ready), .imem_rdata(imem_rdata),
    .if_id_inst(if_id_inst), .if_id_pc4(if_id_pc4),
    .if_id_valid(if_id_valid), .opcode(opcode)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; pc_en = 1'b0; pc_src = 1'b0; jump = 1'b0; flush = 1'b0;
    imem_ready = 1'b0; branch_target = 32'h0; imem_rdata = 32'h0; jump_index = 26'h0;
    step(); step();
    checks++; if (imem_req !== 1'b0) begin errors++; $display("[TB] FAIL reset_req: got %b expected 0", imem_req); end
    checks++; if (imem_addr !== 32'h0) begin errors++; $display("[TB] FAIL reset_addr: got %h expected 00000000", imem_addr); end
    checks++; if (if_id_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid: got %b expected 0", if_id_valid); end
    checks++; if (if_id_inst !== 32'h0) begin errors++; $display("[TB] FAIL reset_inst: got %h expected 00000000", if_id_inst); end
    checks++; if (if_id_pc4 !== 32'h0) begin errors++; $display("[TB] FAIL reset_pc4: got %h expected 00000000", if_id_pc4); end
  endtask

  task automatic test_sequential();
    logic [31:0] words [3];
    words[0] = 32'h0000_0011; words[1] = 32'h0000_0022; words[2] = 32'h0000_0033;
    rst = 1'b0; imem_ready = 1'b1; pc_en = 1'b1;
    step();
    checks++; if (imem_addr !== 32'h0) begin errors++; $display("[TB] FAIL seq_first_addr: got %h expected 00000000", imem_addr); end
    checks++; if (imem_req !== 1'b1) begin errors++; $display("[TB] FAIL seq_first_req: got %b expected 1", imem_req); end
    checks++; if (if_id_valid !== 1'b0) begin errors++; $display("[TB] FAIL seq_first_valid: got %b expected 0", if_id_valid); end
    for (int i = 0; i < 3; i++) begin
      imem_rdata = words[i];
      step();
      checks++; if (if_id_inst !== words[i]) begin errors++; $display("[TB] FAIL seq_inst[%0d]: got %h expected %h", i, if_id_inst, words[i]); end
      checks++; if (if_id_pc4 !== 32'(4 * (i + 1))) begin errors++; $display("[TB] FAIL seq_pc4[%0d]: got %h expected %h", i, if_id_pc4, 32'(4 * (i + 1))); end
      checks++; if (imem_addr !== 32'(4 * (i + 1))) begin errors++; $display("[TB] FAIL seq_addr[%0d]: got %h expected %h", i, imem_addr, 32'(4 * (i + 1))); end
      checks++; if (if_id_valid !== 1'b1) begin errors++; $display("[TB] FAIL seq_valid[%0d]: got %b expected 1", i, if_id_valid); end
    end
  endtask

  task automatic test_stall_ready();
    imem_rdata = 32'h0000_0044;
    step();
    checks++; if (imem_addr !== 32'h10) begin errors++; $display("[TB] FAIL stall_pre_addr: got %h expected 00000010", imem_addr); end
    imem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++; if (imem_addr !== 32'h10) begin errors++; $display("[TB] FAIL stall_addr[%0d]: got %h expected 00000010", i, imem_addr); end
      checks++; if (imem_req !== 1'b1) begin errors++; $display("[TB] FAIL stall_req[%0d]: got %b expected 1", i, imem_req); end
      checks++; if (if_id_inst !== 32'h44 || if_id_valid !== 1'b1) begin errors++; $display("[TB] FAIL stall_ifid[%0d]: got %h/%b expected 00000044/1", i, if_id_inst, if_id_valid); end
    end
    imem_ready = 1'b1; imem_rdata = 32'h0000_0055;
    step();
    checks++; if (if_id_inst !== 32'h55) begin errors++; $display("[TB] FAIL stall_load_inst: got %h expected 00000055", if_id_inst); end
    checks++; if (if_id_pc4 !== 32'h14) begin errors++; $display("[TB] FAIL stall_load_pc4: got %h expected 00000014", if_id_pc4); end
    checks++; if (imem_addr !== 32'h14) begin errors++; $display("[TB] FAIL stall_pc: got %h expected 00000014", imem_addr); end
  endtask

  task automatic test_hold();
    pc_en = 1'b0; imem_rdata = 32'h2008_0005;
    step();
    imem_rdata = 32'hBAD0_BAD0;
    for (int i = 0; i < 2; i++) begin
      checks++; if (imem_req !== 1'b0) begin errors++; $display("[TB] FAIL hold_req[%0d]: got %b expected 0", i, imem_req); end
      checks++; if (if_id_inst !== 32'h55) begin errors++; $display("[TB] FAIL hold_inst[%0d]: got %h expected 00000055", i, if_id_inst); end
      checks++; if (imem_addr !== 32'h14) begin errors++; $display("[TB] FAIL hold_addr[%0d]: got %h expected 00000014", i, imem_addr); end
      if (i == 0) step();
    end
    pc_en = 1'b1;
    step();
    checks++; if (if_id_inst !== 32'h2008_0005) begin errors++; $display("[TB] FAIL hold_release_inst: got %h expected 20080005", if_id_inst); end
    checks++; if (opcode !== 6'b001000) begin errors++; $display("[TB] FAIL hold_opcode: got %b expected 001000", opcode); end
    checks++; if (if_id_pc4 !== 32'h18) begin errors++; $display("[TB] FAIL hold_pc4: got %h expected 00000018", if_id_pc4); end
    checks++; if (imem_addr !== 32'h18 || imem_req !== 1'b1) begin errors++; $display("[TB] FAIL hold_next_fetch: got %h/%b expected 00000018/1", imem_addr, imem_req); end
  endtask

  task automatic test_branch_discard();
    imem_ready = 1'b0; pc_src = 1'b1; branch_target = 32'h40;
    step();
    pc_src = 1'b0;
    checks++; if (imem_addr !== 32'h18 || imem_req !== 1'b1) begin errors++; $display("[TB] FAIL discard_addr: got %h/%b expected 00000018/1", imem_addr, imem_req); end
    checks++; if (if_id_valid !== 1'b0 || if_id_inst !== 32'h0) begin errors++; $display("[TB] FAIL discard_squash: got %b/%h expected 0/00000000", if_id_valid, if_id_inst); end
    step();
    checks++; if (imem_addr !== 32'h18) begin errors++; $display("[TB] FAIL discard_wait_addr: got %h expected 00000018", imem_addr); end
    imem_ready = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    step();
    checks++; if (imem_addr !== 32'h40) begin errors++; $display("[TB] FAIL discard_new_addr: got %h expected 00000040", imem_addr); end
    checks++; if (if_id_valid !== 1'b0 || if_id_inst !== 32'h0) begin errors++; $display("[TB] FAIL discard_drop: got %b/%h expected 0/00000000", if_id_valid, if_id_inst); end
    imem_rdata = 32'h0000_0066;
    step();
    checks++; if (if_id_inst !== 32'h66 || if_id_pc4 !== 32'h44) begin errors++; $display("[TB] FAIL discard_target_load: got %h/%h expected 00000066/00000044", if_id_inst, if_id_pc4); end
  endtask

  task automatic test_jump_priority();
    pc_src = 1'b1; branch_target = 32'h1000_0000;
    step();
    pc_src = 1'b0;
    checks++; if (imem_addr !== 32'h1000_0000) begin errors++; $display("[TB] FAIL jump_setup_addr: got %h expected 10000000", imem_addr); end
    imem_rdata = 32'h0800_0010;
    step();
    checks++; if (if_id_pc4 !== 32'h1000_0004) begin errors++; $display("[TB] FAIL jump_setup_pc4: got %h expected 10000004", if_id_pc4); end
    jump = 1'b1; pc_src = 1'b1; branch_target = 32'h80; jump_index = 26'h10;
    step();
    jump = 1'b0; pc_src = 1'b0;
    checks++; if (imem_addr !== 32'h1000_0040) begin errors++; $display("[TB] FAIL jump_target: got %h expected 10000040", imem_addr); end
    checks++; if (if_id_valid !== 1'b0 || if_id_inst !== 32'h0) begin errors++; $display("[TB] FAIL jump_squash: got %b/%h expected 0/00000000", if_id_valid, if_id_inst); end
  endtask

  task automatic test_discard_last_wins();
    imem_ready = 1'b0; pc_src = 1'b1; branch_target = 32'h100;
    step();
    checks++; if (imem_addr !== 32'h1000_0040) begin errors++; $display("[TB] FAIL lastwins_old_addr: got %h expected 10000040", imem_addr); end
    branch_target = 32'h200;
    step();
    pc_src = 1'b0;
    checks++; if (imem_addr !== 32'h1000_0040) begin errors++; $display("[TB] FAIL lastwins_hold_addr: got %h expected 10000040", imem_addr); end
    imem_ready = 1'b1;
    step();
    checks++; if (imem_addr !== 32'h200) begin errors++; $display("[TB] FAIL lastwins_target: got %h expected 00000200", imem_addr); end
  endtask

  task automatic test_flush();
    imem_rdata = 32'h0000_0070;
    step();
    checks++; if (if_id_inst !== 32'h70 || if_id_valid !== 1'b1) begin errors++; $display("[TB] FAIL flush_pre: got %h/%b expected 00000070/1", if_id_inst, if_id_valid); end
    flush = 1'b1; imem_rdata = 32'h0000_0077;
    step();
    flush = 1'b0;
    checks++; if (if_id_valid !== 1'b0 || if_id_inst !== 32'h0) begin errors++; $display("[TB] FAIL flush_squash: got %b/%h expected 0/00000000", if_id_valid, if_id_inst); end
    checks++; if (imem_addr !== 32'h208) begin errors++; $display("[TB] FAIL flush_pc_advance: got %h expected 00000208", imem_addr); end
    imem_rdata = 32'h0000_0088;
    step();
    checks++; if (if_id_inst !== 32'h88 || if_id_pc4 !== 32'h20C) begin errors++; $display("[TB] FAIL flush_resume: got %h/%h expected 00000088/0000020c", if_id_inst, if_id_pc4); end
  endtask

  task automatic test_wrap();
    pc_src = 1'b1; branch_target = 32'hFFFF_FFFC;
    step();
    pc_src = 1'b0;
    checks++; if (imem_addr !== 32'hFFFF_FFFC) begin errors++; $display("[TB] FAIL wrap_addr: got %h expected fffffffc", imem_addr); end
    imem_rdata = 32'h0000_0099;
    step();
    checks++; if (if_id_pc4 !== 32'h0 || imem_addr !== 32'h0) begin errors++; $display("[TB] FAIL wrap_pc4_addr: got %h/%h expected 00000000/00000000", if_id_pc4, imem_addr); end
    checks++; if (if_id_inst !== 32'h99 || if_id_valid !== 1'b1) begin errors++; $display("[TB] FAIL wrap_inst: got %h/%b expected 00000099/1", if_id_inst, if_id_valid); end
  endtask

  task automatic test_reset_in_discard();
    imem_rdata = 32'h0000_00AA;
    step();
    imem_ready = 1'b0; pc_src = 1'b1; branch_target = 32'h300;
    step();
    pc_src = 1'b0;
    checks++; if (imem_addr !== 32'h4 || imem_req !== 1'b1) begin errors++; $display("[TB] FAIL rstdisc_pre: got %h/%b expected 00000004/1", imem_addr, imem_req); end
    rst = 1'b1;
    step();
    checks++; if (imem_req !== 1'b0 || imem_addr !== 32'h0) begin errors++; $display("[TB] FAIL rstdisc_req_addr: got %b/%h expected 0/00000000", imem_req, imem_addr); end
    checks++; if (if_id_valid !== 1'b0 || if_id_inst !== 32'h0) begin errors++; $display("[TB] FAIL rstdisc_ifid: got %b/%h expected 0/00000000", if_id_valid, if_id_inst); end
    rst = 1'b0; imem_ready = 1'b1; pc_src = 1'b1; branch_target = 32'h500;
    step();
    pc_src = 1'b0;
    checks++; if (imem_addr !== 32'h0 || imem_req !== 1'b1) begin errors++; $display("[TB] FAIL rstdisc_idle_ignore: got %h/%b expected 00000000/1", imem_addr, imem_req); end
    imem_rdata = 32'h0000_00BB;
    step();
    checks++; if (imem_addr !== 32'h4 || if_id_inst !== 32'hBB) begin errors++; $display("[TB] FAIL rstdisc_resume: got %h/%h expected 00000004/000000bb", imem_addr, if_id_inst); end
  endtask

  initial begin
    $display("[TB] instr_fetch directed test start");
    test_reset();
    test_sequential();
    test_stall_ready();
    test_hold();
    test_branch_discard();
    test_jump_priority();
    test_discard_last_wins();
    test_flush();
    test_wrap();
    test_reset_in_discard();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
